// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: turns UART command frames into single OCP master transactions and returns one response byte.
module uart_cmd_bridge #(
    parameter logic [15:0] P_TIMEOUT   = 16'd50000,
    parameter logic [7:0]  P_CMD_WRITE = 8'h57,
    parameter logic [7:0]  P_CMD_READ  = 8'h52,
    parameter logic [7:0]  P_ACK       = 8'h4B,
    parameter logic [7:0]  P_NAK       = 8'h45
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] MCmd,
    output logic [7:0] MAddr,
    output logic [7:0] MData,
    input  logic       SCmdAccept,
    input  logic [7:0] SData,
    input  logic [1:0] SResp,
    output logic [2:0] bridge_state,
    output logic       overrun
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        CMD      = 3'd3,
        RESP     = 3'd4,
        TX       = 3'd5
    } state_t;

    state_t      state, state_d;
    logic        is_read, is_read_d;
    logic [2:0]  mcmd_d;
    logic [7:0]  maddr_d, mdata_d, tx_data_d;
    logic        tx_valid_d, overrun_d, timed_out;
    logic [15:0] cnt, cnt_d;

    assign bridge_state = state;
    assign timed_out    = cnt == P_TIMEOUT - 16'd1;

    always_comb begin
        state_d    = state;
        is_read_d  = is_read;
        mcmd_d     = MCmd;
        maddr_d    = MAddr;
        mdata_d    = MData;
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;
        cnt_d      = '0;
        overrun_d  = overrun | (rx_valid && (state == CMD || state == RESP || state == TX));
        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == P_CMD_WRITE || rx_data == P_CMD_READ)) begin
                    is_read_d = rx_data == P_CMD_READ;
                    state_d   = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    maddr_d = rx_data;
                    mdata_d = is_read ? 8'h00 : MData;
                    mcmd_d  = is_read ? 3'b010 : MCmd;
                    state_d = is_read ? CMD : GET_DATA;
                end else if (timed_out) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    mdata_d = rx_data;
                    mcmd_d  = 3'b001;
                    state_d = CMD;
                end else if (timed_out) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            CMD: begin
                if (SCmdAccept) begin
                    mcmd_d  = 3'b000;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (SResp != 2'b00) begin
                    tx_data_d  = SResp == 2'b01 ? (is_read ? SData : P_ACK) : P_NAK;
                    tx_valid_d = 1'b1;
                    state_d    = TX;
                end
            end
            TX: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_read  <= 1'b0;
            MCmd     <= 3'b000;
            MAddr    <= 8'h00;
            MData    <= 8'h00;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            overrun  <= 1'b0;
            cnt      <= 16'd0;
        end else begin
            state    <= state_d;
            is_read  <= is_read_d;
            MCmd     <= mcmd_d;
            MAddr    <= maddr_d;
            MData    <= mdata_d;
            tx_data  <= tx_data_d;
            tx_valid <= tx_valid_d;
            overrun  <= overrun_d;
            cnt      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge: directed and randomized frames checked against a transaction-level model of the bridge.
module tb_uart_cmd_bridge;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] MCmd;
    logic [7:0] MAddr;
    logic [7:0] MData;
    logic       SCmdAccept;
    logic [7:0] SData;
    logic [1:0] SResp;
    logic [2:0] bridge_state;
    logic       overrun;

    int   vectors = 0;
    int   errs = 0;
    logic exp_ov = 1'b0;

    uart_cmd_bridge #(.P_TIMEOUT(16'd8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .SCmdAccept(SCmdAccept),
        .SData(SData), .SResp(SResp), .bridge_state(bridge_state), .overrun(overrun)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] exp_tx(input logic rd, input logic [1:0] resp, input logic [7:0] sd);
        return resp == 2'b01 ? (rd ? sd : 8'h4B) : 8'h45;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        step;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) step;
    endtask

    task automatic chk_reset;
        chk("rst_state", bridge_state, 0);
        chk("rst_mcmd", MCmd, 0);
        chk("rst_maddr", MAddr, 0);
        chk("rst_mdata", MData, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_ovr", overrun, 0);
    endtask

    task automatic frame(input logic rd, input logic [7:0] a, input logic [7:0] d, input int gap);
        send(rd ? 8'h52 : 8'h57, gap);
        chk("st_get_addr", bridge_state, 1);
        chk("mcmd_idle_addr", MCmd, 0);
        if (rd) send(a, 0);
        else begin
            send(a, gap);
            chk("st_get_data", bridge_state, 2);
            send(d, 0);
        end
    endtask

    task automatic cmd_phase(input logic rd, input logic [7:0] a, input logic [7:0] d, input int acc_delay);
        logic [2:0] ec;
        logic [7:0] ed;
        ec = rd ? 3'b010 : 3'b001;
        ed = rd ? 8'h00 : d;
        SCmdAccept = acc_delay == 0;
        chk("st_cmd", bridge_state, 3);
        chk("mcmd", MCmd, ec);
        chk("maddr", MAddr, a);
        chk("mdata", MData, ed);
        for (int k = 0; k < acc_delay; k++) begin
            step;
            chk("mcmd_hold", MCmd, ec);
        end
        SCmdAccept = 1'b1;
        step;
        chk("mcmd_after_accept", MCmd, 0);
        chk("st_resp", bridge_state, 4);
        chk("maddr_held", MAddr, a);
        chk("mdata_held", MData, ed);
    endtask

    task automatic resp_phase(input logic rd, input logic [1:0] resp, input logic [7:0] sd,
                              input int delay, input logic inject);
        SResp = 2'b00;
        for (int k = 0; k < delay; k++) begin
            if (inject && k == 0) begin
                rx_data  = 8'($urandom);
                rx_valid = 1'b1;
                exp_ov   = 1'b1;
            end
            step;
            rx_valid = 1'b0;
            chk("st_wait_resp", bridge_state, 4);
            chk("txv_wait_resp", tx_valid, 0);
            chk("overrun", overrun, exp_ov);
        end
        SResp = resp;
        SData = sd;
        step;
        SResp = 2'b00;
        SData = 8'($urandom);
        chk("txv_set", tx_valid, 1);
        chk("txd", tx_data, exp_tx(rd, resp, sd));
        chk("st_tx", bridge_state, 5);
    endtask

    task automatic tx_phase(input int ready_delay, input logic [7:0] e);
        tx_ready = 1'b0;
        for (int k = 0; k < ready_delay; k++) begin
            SResp = 2'($urandom);
            step;
            chk("txv_hold", tx_valid, 1);
            chk("txd_hold", tx_data, e);
        end
        SResp    = 2'b00;
        tx_ready = 1'b1;
        step;
        tx_ready = 1'b0;
        chk("txv_drop", tx_valid, 0);
        chk("st_idle", bridge_state, 0);
        chk("overrun_end", overrun, exp_ov);
    endtask

    task automatic txn(input logic rd, input logic [7:0] a, input logic [7:0] d, input int gap,
                       input int acc, input logic [1:0] resp, input logic [7:0] sd,
                       input int rdel, input logic inject, input int ready);
        frame(rd, a, d, gap);
        cmd_phase(rd, a, d, acc);
        resp_phase(rd, resp, sd, rdel, inject);
        tx_phase(ready, exp_tx(rd, resp, sd));
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        SCmdAccept = 1'b1; SData = 8'h00; SResp = 2'b00;
        repeat (2) step;
        chk_reset;
        rst_n = 1'b1;
        step;

        txn(1'b0, 8'h10, 8'hA5, 2, 0, 2'b01, 8'h00, 2, 1'b0, 3);
        txn(1'b1, 8'h80, 8'h00, 1, 5, 2'b01, 8'h3C, 1, 1'b0, 10);
        txn(1'b1, 8'h05, 8'h00, 0, 0, 2'b11, 8'h99, 0, 1'b0, 0);
        txn(1'b0, 8'h33, 8'h44, 0, 1, 2'b10, 8'h00, 3, 1'b0, 1);

        send(8'h57, 0);
        send(8'h20, 0);
        for (int k = 0; k < 7; k++) begin
            step;
            chk("to_state_hold", bridge_state, 2);
            chk("to_mcmd_zero", MCmd, 0);
        end
        step;
        chk("to_state_idle", bridge_state, 0);
        chk("to_mcmd_idle", MCmd, 0);
        chk("to_txv", tx_valid, 0);

        send(8'h57, 0);
        send(8'h21, 0);
        repeat (7) step;
        send(8'h6E, 0);
        cmd_phase(1'b0, 8'h21, 8'h6E, 0);
        resp_phase(1'b0, 2'b01, 8'h00, 0, 1'b0);
        tx_phase(0, 8'h4B);

        send(8'h00, 0);
        send(8'hFF, 0);
        chk("junk_state", bridge_state, 0);
        chk("junk_ovr", overrun, 0);

        txn(1'b1, 8'h7A, 8'h00, 0, 0, 2'b01, 8'hC3, 2, 1'b1, 2);

        for (int i = 0; i < 16; i++) begin
            logic       rd;
            logic [1:0] resp;
            rd   = 1'($urandom);
            resp = 2'($urandom_range(1, 3));
            txn(rd, 8'($urandom), 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), resp,
                8'($urandom), $urandom_range(1, 4), 1'($urandom), $urandom_range(0, 4));
        end

        frame(1'b1, 8'h40, 8'h00, 0);
        SCmdAccept = 1'b0;
        #2 rst_n = 1'b0;
        #1 exp_ov = 1'b0;
        chk_reset;
        step;
        rst_n = 1'b1;
        SCmdAccept = 1'b1;
        step;

        frame(1'b0, 8'h55, 8'h66, 0);
        cmd_phase(1'b0, 8'h55, 8'h66, 0);
        resp_phase(1'b0, 2'b01, 8'h00, 1, 1'b1);
        #2 rst_n = 1'b0;
        #1 exp_ov = 1'b0;
        chk_reset;
        step;
        rst_n = 1'b1;
        step;

        txn(1'b1, 8'h12, 8'h00, 1, 2, 2'b01, 8'h9E, 1, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
